uat_tx: RTL and testbench

UAT_TX -- requirements
Module: uat_tx

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uat_sm.sv | 51 +++++
 rtl/uat_tx.sv | 123 ++++++++++++
 tb/tb_uat_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot transmitter states and oversampling constants.
// Latency: n/a (package only).
// Backpressure: n/a.
package uart_pkg;

    // Each bit on the line lasts OVERSAMPLE cycles of the 16x clock.
    localparam int OVERSAMPLE = 16;
    localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);
    // One cycle before the end of a bit; used to line a registered pulse
    // up with the final cycle of the stop bit.
    localparam logic [3:0] PRE_LAST_SAMPLE = 4'(OVERSAMPLE - 2);

    // Wide enough to count up to 8 data bits (index 0..7).
    localparam int SHIFT_CNT_W = 3;

    typedef enum logic [3:0] {
        IDLE         = 4'b0001,
        START_BIT_ST = 4'b0010,
        DATA_BITS_ST = 4'b0100,
        STOP_BIT_ST  = 4'b1000
    } uat_state_e;

endpackage

// File: rtl/uat_sm.sv
// Transmitter state register and next-state decode.
// Latency: state updates one clk_16x edge after its inputs; state_nxt is combinational.
// Backpressure: none; a loaded holding register is consumed from IDLE or the end of STOP.
//
// Ports: clk_16x/rst_p clock and synchronous active-high reset; hold_full,
// sample_count, shift_count from the datapath; state (registered) and
// state_nxt (its next value, so the datapath can register outputs in step).
module uat_sm
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic                   clk_16x,
    input  logic                   rst_p,
    input  logic                   hold_full,
    input  logic [3:0]             sample_count,
    input  logic [SHIFT_CNT_W-1:0] shift_count,
    output uat_state_e             state,
    output uat_state_e             state_nxt
);

    localparam logic [SHIFT_CNT_W-1:0] LAST_BIT = SHIFT_CNT_W'(DATA_BITS - 1);

    logic bit_end;
    assign bit_end = (sample_count == LAST_SAMPLE);

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:         state_nxt = hold_full ? START_BIT_ST : IDLE;
            START_BIT_ST: state_nxt = bit_end ? DATA_BITS_ST : START_BIT_ST;
            DATA_BITS_ST: state_nxt = (bit_end && shift_count == LAST_BIT) ? STOP_BIT_ST
                                                                            : DATA_BITS_ST;
            // A byte waiting at the end of the stop bit starts the next frame
            // directly, with no idle cycle in between.
            STOP_BIT_ST:  state_nxt = !bit_end  ? STOP_BIT_ST  :
                                      hold_full ? START_BIT_ST : IDLE;
            // Any corrupted encoding falls back to IDLE on the next edge.
            default:      state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_16x) begin
        if (rst_p) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

endmodule

// File: rtl/uat_tx.sv
// UART transmitter: one-entry holding register feeding a shifter, N data bits, no parity.
// Latency: byte accepted at edge N drives the start bit from edge N+1; din_rdy back high at N+2.
// Backpressure: din_rdy low while a byte is held; din is sampled only when din_vld && din_rdy.
//
// Ports: clk_16x (16x baud) and rst_p (synchronous, active-high); din/din_vld/din_rdy
// byte handshake; tx_out serial line (idles high); tx_busy high outside IDLE;
// tx_done one-cycle pulse on the final stop-bit cycle; start/data/stop state flags.
module uat_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8     // legal range 5..8
) (
    input  logic                 clk_16x,
    input  logic                 rst_p,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 din_vld,
    output logic                 din_rdy,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 start_bit_sig,
    output logic                 data_bits_sig,
    output logic                 stop_bit_sig
);

    localparam logic [SHIFT_CNT_W-1:0] LAST_BIT = SHIFT_CNT_W'(DATA_BITS - 1);

    logic [DATA_BITS-1:0]   hold_dat;
    logic                   hold_full;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [DATA_BITS-1:0]   shift_nxt;
    logic [3:0]             sample_count;
    logic [SHIFT_CNT_W-1:0] shift_count;
    uat_state_e             state;
    uat_state_e             state_nxt;
    logic                   accept;
    logic                   load;
    logic                   bit_end;

    uat_sm #(
        .DATA_BITS (DATA_BITS)
    ) u_sm (
        .clk_16x      (clk_16x),
        .rst_p        (rst_p),
        .hold_full    (hold_full),
        .sample_count (sample_count),
        .shift_count  (shift_count),
        .state        (state),
        .state_nxt    (state_nxt)
    );

    assign accept  = din_vld && din_rdy;
    assign bit_end = (sample_count == LAST_SAMPLE);
    // Entering START_BIT_ST from anywhere else means the held byte moves to the shifter.
    assign load    = (state_nxt == START_BIT_ST) && (state != START_BIT_ST);

    // The state register bits are the flags, so they are registered and all low in IDLE.
    assign start_bit_sig = state[1];
    assign data_bits_sig = state[2];
    assign stop_bit_sig  = state[3];

    always_comb begin
        shift_nxt = shift_reg;
        if (load) begin
            shift_nxt = hold_dat;
        end else if (state == DATA_BITS_ST && bit_end) begin
            shift_nxt = shift_reg >> 1;
        end
    end

    always_ff @(posedge clk_16x) begin
        if (rst_p) begin
            hold_dat     <= '0;
            hold_full    <= 1'b0;
            din_rdy      <= 1'b1;
            shift_reg    <= '0;
            sample_count <= '0;
            shift_count  <= '0;
            tx_out       <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            if (accept) begin
                hold_dat  <= din;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end

            // Drops on the accepting edge itself and returns one edge after the
            // holding register empties, so a second byte can never overwrite one
            // that is still waiting or being loaded.
            din_rdy <= !hold_full && !accept;

            shift_reg <= shift_nxt;

            if (load || state_nxt == IDLE) begin
                sample_count <= '0;
            end else begin
                sample_count <= sample_count + 4'd1;   // wraps 15 -> 0 at each bit boundary
            end

            if (load) begin
                shift_count <= '0;
            end else if (state == DATA_BITS_ST && bit_end) begin
                shift_count <= (shift_count == LAST_BIT) ? '0 : shift_count + SHIFT_CNT_W'(1);
            end

            // Line level and busy follow the state being entered, so they change
            // on the same edge as the state register.
            case (state_nxt)
                START_BIT_ST: tx_out <= 1'b0;
                DATA_BITS_ST: tx_out <= shift_nxt[0];
                default:      tx_out <= 1'b1;
            endcase
            tx_busy <= (state_nxt != IDLE);

            // Set one cycle early so the registered pulse sits on the last stop-bit cycle.
            tx_done <= (state == STOP_BIT_ST) && (sample_count == PRE_LAST_SAMPLE);
        end
    end

endmodule

// File: tb/tb_uat_tx.sv
module tb_uat_tx;

    logic       clk = 1'b0;
    logic       rst_p;
    logic [7:0] din8;
    logic       din_vld8;
    logic       din_rdy8, tx_out8, tx_busy8, tx_done8, start8, data8, stop8;
    logic [4:0] din5;
    logic       din_vld5;
    logic       din_rdy5, tx_out5, tx_busy5, tx_done5, start5, data5, stop5;

    uat_tx #(.DATA_BITS(8)) u_dut8 (
        .clk_16x(clk), .rst_p(rst_p), .din(din8), .din_vld(din_vld8), .din_rdy(din_rdy8),
        .tx_out(tx_out8), .tx_busy(tx_busy8), .tx_done(tx_done8),
        .start_bit_sig(start8), .data_bits_sig(data8), .stop_bit_sig(stop8)
    );

    uat_tx #(.DATA_BITS(5)) u_dut5 (
        .clk_16x(clk), .rst_p(rst_p), .din(din5), .din_vld(din_vld5), .din_rdy(din_rdy5),
        .tx_out(tx_out5), .tx_busy(tx_busy5), .tx_done(tx_done5),
        .start_bit_sig(start5), .data_bits_sig(data5), .stop_bit_sig(stop5)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    typedef struct { logic [7:0] din; logic [9:0] frame; } vec_t;
    typedef struct { logic [9:0] frame; int acc; } sb_t;
    vec_t tbl[6];
    sb_t  sb[$];

    // ---------------- monitor / scoreboard for the 8-bit instance ----------------
    bit         m_active = 1'b0;
    bit         m_bad, m_done_bad;
    int         m_cnt, m_slot, m_exp_start, nframe = 0;
    int         last_start = -1000;
    logic [9:0] m_frame;
    logic [4:0] cur, req, m_act, m_req;
    sb_t        ent;

    always @(negedge clk) begin
        if (!m_active && tx_out8 === 1'b0 && rst_p !== 1'b1) begin
            m_active = 1'b1;
            m_cnt = 0; m_bad = 1'b0; m_done_bad = 1'b0;
            m_act = '0; m_req = '0;
            if (sb.size() == 0) begin
                chk(1'b0, "unexpected_frame", cyc, 0);
                m_frame = 10'h3FF;
                m_exp_start = cyc;
            end else begin
                ent = sb.pop_front();
                m_frame = ent.frame;
                m_exp_start = (ent.acc + 1 > last_start + 160) ? ent.acc + 1 : last_start + 160;
            end
            chk(cyc == m_exp_start, "frame_start_cycle", cyc, m_exp_start);
            last_start = cyc;
        end
        if (m_active) begin
            m_slot = m_cnt / 16;
            req = {m_frame[m_slot],
                   (m_slot == 0) ? 3'b100 : (m_slot <= 8) ? 3'b010 : 3'b001,
                   1'b1};
            cur = {tx_out8, start8, data8, stop8, tx_busy8};
            if (cur !== req && !m_bad) begin
                m_bad = 1'b1; m_act = cur; m_req = req;
            end
            if (tx_done8 !== (m_cnt == 159)) m_done_bad = 1'b1;
            if (m_cnt % 16 == 15) begin
                chk(!m_bad, $sformatf("frame%0d_slot%0d {line,start,data,stop,busy}", nframe, m_slot),
                    m_act, m_req);
                m_bad = 1'b0;
            end
            if (m_cnt == 159) begin
                chk(!m_done_bad, $sformatf("frame%0d_tx_done_only_last_cycle", nframe), m_done_bad, 0);
                m_active = 1'b0;
                nframe++;
            end
            m_cnt++;
        end else if (tx_done8 !== 1'b0 && rst_p !== 1'b1) begin
            chk(1'b0, "stray_tx_done", tx_done8, 0);
        end
        // A reset aborts any frame in flight and discards whatever was queued.
        if (rst_p === 1'b1) begin
            m_active = 1'b0;
            sb.delete();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] d, input logic [9:0] f);
        int  t = 0;
        sb_t e;
        while (din_rdy8 !== 1'b1 && t < 1000) begin @(posedge clk); #1; t++; end
        if (t >= 1000) chk(1'b0, "din_rdy_timeout", t, 1000);
        din8 = d; din_vld8 = 1'b1;
        @(posedge clk); #1;
        e.frame = f; e.acc = cyc;
        sb.push_back(e);
        din_vld8 = 1'b0;
        din8 = 8'($urandom);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || m_active || tx_busy8 !== 1'b0) && t < 3000) begin
            @(posedge clk); #1; t++;
        end
        chk(t < 3000, "drain_timeout", t, 3000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        int  a0, e, t, accepts;
        bit  rdy_now, seen_low, seen_done, bad5, done_bad5;
        logic [6:0] f5;
        logic [3:0] req5, cur5, act5, exp5;

        tbl[0] = '{8'hA5, 10'b1_10100101_0};
        tbl[1] = '{8'h3C, 10'b1_00111100_0};
        tbl[2] = '{8'h01, 10'b1_00000001_0};
        tbl[3] = '{8'h80, 10'b1_10000000_0};
        tbl[4] = '{8'hF0, 10'b1_11110000_0};
        tbl[5] = '{8'h96, 10'b1_10010110_0};

        rst_p = 1'b1; din8 = '0; din_vld8 = 1'b0; din5 = '0; din_vld5 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_p = 1'b0;

        // Reset state
        @(negedge clk);
        chk(tx_out8 === 1'b1,  "reset_tx_out",  tx_out8,  1);
        chk(din_rdy8 === 1'b1, "reset_din_rdy", din_rdy8, 1);
        chk(tx_busy8 === 1'b0, "reset_tx_busy", tx_busy8, 0);
        chk(tx_done8 === 1'b0, "reset_tx_done", tx_done8, 0);
        chk({start8, data8, stop8} === 3'b000, "reset_state_sigs", {start8, data8, stop8}, 0);
        chk({tx_out5, din_rdy5, tx_busy5, tx_done5, start5, data5, stop5} === 7'b1100000,
            "reset_dut5_outputs", {tx_out5, din_rdy5, tx_busy5, tx_done5, start5, data5, stop5},
            7'b1100000);
        @(posedge clk); #1;

        // Table of bytes sent as fast as din_rdy allows: first from idle, the rest back-to-back.
        for (int i = 0; i < 6; i++) send(tbl[i].din, tbl[i].frame);
        wait_idle();

        // 00 then FF while the first frame is still in its start bit.
        send(8'h00, 10'b1_00000000_0);
        a0 = cyc;
        send(8'hFF, 10'b1_11111111_0);
        t = 0;
        while (din_rdy8 !== 1'b1 && t < 400) begin @(posedge clk); #1; t++; end
        chk(cyc == a0 + 162, "din_rdy_rise_after_second_load", cyc, a0 + 162);
        wait_idle();

        // din_vld held high; din scrambled whenever din_rdy is low.
        accepts = 0;
        din_vld8 = 1'b1;
        for (int k = 0; k < 400; k++) begin
            rdy_now = din_rdy8;
            din8 = rdy_now ? 8'h3C : 8'($urandom);
            @(posedge clk); #1;
            if (rdy_now) begin
                sb_t en;
                en.frame = 10'b1_00111100_0; en.acc = cyc;
                sb.push_back(en);
                accepts++;
            end
        end
        din_vld8 = 1'b0;
        chk(accepts >= 2, "held_vld_accepts", accepts, 2);
        wait_idle();

        // Reset in the middle of the data bits with a second byte held.
        send(8'hA5, 10'b1_10100101_0);
        e = cyc;
        send(8'h5A, 10'b1_01011010_0);
        while (cyc < e + 69) begin @(posedge clk); #1; end
        rst_p = 1'b1;
        @(posedge clk); #1;
        rst_p = 1'b0;
        @(negedge clk);
        chk(tx_out8 === 1'b1,  "midframe_reset_tx_out",  tx_out8,  1);
        chk(din_rdy8 === 1'b1, "midframe_reset_din_rdy", din_rdy8, 1);
        chk(tx_busy8 === 1'b0, "midframe_reset_tx_busy", tx_busy8, 0);
        chk({start8, data8, stop8} === 3'b000, "midframe_reset_state", {start8, data8, stop8}, 0);
        seen_low = 1'b0; seen_done = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (tx_out8 !== 1'b1)  seen_low = 1'b1;
            if (tx_done8 !== 1'b0) seen_done = 1'b1;
        end
        chk(!seen_low,  "after_reset_line_stays_high", seen_low, 0);
        chk(!seen_done, "after_reset_no_tx_done", seen_done, 0);

        // 5-bit instance: 5'h15 -> 112-cycle frame.
        @(posedge clk); #1;
        din5 = 5'h15; din_vld5 = 1'b1;
        @(posedge clk); #1;
        din_vld5 = 1'b0;
        f5 = 7'b1_10101_0;
        bad5 = 1'b0; done_bad5 = 1'b0; act5 = '0; exp5 = '0;
        @(negedge clk);                         // cycle of the accepting edge
        for (int c = 1; c <= 112; c++) begin
            int s;
            @(negedge clk);
            s = (c - 1) / 16;
            req5 = {f5[s], (s == 0) ? 3'b100 : (s <= 5) ? 3'b010 : 3'b001};
            cur5 = {tx_out5, start5, data5, stop5};
            if (cur5 !== req5 && !bad5) begin bad5 = 1'b1; act5 = cur5; exp5 = req5; end
            if (tx_done5 !== (c == 112) || tx_busy5 !== 1'b1) done_bad5 = 1'b1;
            if ((c - 1) % 16 == 15) begin
                chk(!bad5, $sformatf("dut5_slot%0d {line,start,data,stop}", s), act5, exp5);
                bad5 = 1'b0;
            end
        end
        chk(!done_bad5, "dut5_busy_and_done", done_bad5, 0);
        @(negedge clk);
        chk({tx_out5, tx_busy5, tx_done5} === 3'b100, "dut5_idle_after_frame",
            {tx_out5, tx_busy5, tx_done5}, 3'b100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
